// File: rtl/distance_uart_reporter.sv
// distance_uart_reporter: converts each published 16-bit distance sample (mm)
// to a decimal ASCII line ("1234\r\n", or "OOR\r\n" when out of range) and
// streams it 8N1 on uart_tx. One sample may wait while a line is in flight;
// overwriting a waiting sample bumps drop_cnt.
// Ports:
//   fastclk    system clock
//   rst        synchronous active-high reset
//   dist_valid one-cycle strobe qualifying dist_mm
//   dist_mm    unsigned distance sample in mm
//   uart_tx    UART serial output, idle high
//   busy       high from sample capture until its line's last stop bit ends
//   drop_cnt   saturating count of overwritten pending samples
module distance_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned OOR_MM       = 8190
) (
  input  logic        fastclk,
  input  logic        rst,
  input  logic        dist_valid,
  input  logic [15:0] dist_mm,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0] OOR_VAL = 16'(OOR_MM);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_LOAD, S_START, S_DATA, S_STOP, S_DISPATCH
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       work_q, work_d;
  logic [19:0]       bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              oor_q, oor_d;
  logic [6:0][7:0]   chars_q, chars_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        bit_q, bit_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [15:0]       pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [7:0]        drop_q, drop_d;
  logic              busy_q, busy_d;
  logic              tx_q, tx_d;

  // Double-dabble correction: add 3 to every BCD digit >= 5 before the shift.
  logic [19:0] bcd_adj;
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Character list: digits with leading zeros suppressed, then CR LF.
  logic [2:0]      nd;
  logic [27:0]     aligned;
  logic [6:0][7:0] load_chars;
  logic [2:0]      load_n;
  always_comb begin
    nd = 3'd1;
    if      (bcd_q[19:16] != 4'd0) nd = 3'd5;
    else if (bcd_q[15:12] != 4'd0) nd = 3'd4;
    else if (bcd_q[11:8]  != 4'd0) nd = 3'd3;
    else if (bcd_q[7:4]   != 4'd0) nd = 3'd2;
    // Left-justify the significant digits so character i is nibble i from the top.
    case (nd)
      3'd5:    aligned = {bcd_q, 8'h00};
      3'd4:    aligned = {bcd_q[15:0], 12'h000};
      3'd3:    aligned = {bcd_q[11:0], 16'h0000};
      3'd2:    aligned = {bcd_q[7:0], 20'h00000};
      default: aligned = {bcd_q[3:0], 24'h000000};
    endcase
    for (int i = 0; i < 7; i++) begin
      load_chars[i] = 8'h00;
      if (3'(i) < nd)                    load_chars[i] = {4'h3, aligned[27-4*i -: 4]};
      else if (3'(i) == nd)              load_chars[i] = 8'h0D;
      else if (3'(i) == 3'(nd + 3'd1))   load_chars[i] = 8'h0A;
    end
    load_n = 3'(nd + 3'd2);
    if (oor_q) begin
      load_chars = {8'h00, 8'h00, 8'h0A, 8'h0D, 8'h52, 8'h4F, 8'h4F};
      load_n     = 3'd5;
    end
  end

  // State register.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      work_q       <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      oor_q        <= 1'b0;
      chars_q      <= '0;
      nbytes_q     <= '0;
      idx_q        <= '0;
      bit_q        <= '0;
      baud_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      drop_q       <= '0;
      busy_q       <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      oor_q        <= oor_d;
      chars_q      <= chars_d;
      nbytes_q     <= nbytes_d;
      idx_q        <= idx_d;
      bit_q        <= bit_d;
      baud_q       <= baud_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
      tx_q         <= tx_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    oor_d        = oor_q;
    chars_d      = chars_q;
    nbytes_d     = nbytes_q;
    idx_d        = idx_q;
    bit_d        = bit_q;
    baud_d       = baud_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    drop_d       = drop_q;
    busy_d       = busy_q;

    // Samples arriving while busy go to pending; DISPATCH sees this write.
    if (dist_valid && state_q != S_IDLE) begin
      pend_d       = dist_mm;
      pend_valid_d = 1'b1;
      if (pend_valid_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (dist_valid) begin
          work_d  = dist_mm;
          oor_d   = (dist_mm >= OOR_VAL);
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {bcd_d, work_d} = {bcd_adj[18:0], work_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_LOAD;
      end
      S_LOAD: begin
        chars_d  = load_chars;
        nbytes_d = load_n;
        idx_d    = '0;
        bit_d    = '0;
        baud_d   = '0;
        state_d  = S_START;
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (idx_q == 3'(nbytes_q - 3'd1)) begin
            state_d = S_DISPATCH;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DISPATCH: begin
        if (pend_valid_d) begin
          work_d       = pend_d;
          oor_d        = (pend_d >= OOR_VAL);
          bcd_d        = '0;
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          state_d      = S_CONVERT;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so it changes with the state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = chars_q[idx_q][bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_distance_uart_reporter.sv
// tb_distance_uart_reporter: directed checks of distance_uart_reporter line
// text, UART timing, pending/overrun handling and mid-frame reset.
module tb_distance_uart_reporter;

  localparam int CPB  = 23;
  localparam int CHAR = 10 * CPB;

  logic        fastclk = 1'b0;
  logic        rst = 1'b1;
  logic        dist_valid = 1'b0;
  logic [15:0] dist_mm = 16'h0000;
  logic        uart_tx;
  logic        busy;
  logic [7:0]  drop_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  distance_uart_reporter #(.CLKS_PER_BIT(CPB), .OOR_MM(8190)) dut (
    .fastclk   (fastclk),
    .rst       (rst),
    .dist_valid(dist_valid),
    .dist_mm   (dist_mm),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 fastclk = ~fastclk;
  always @(posedge fastclk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge fastclk);
  endtask

  // Called at a negedge: one-cycle strobe, then dist_mm goes to junk.
  task automatic pulse(input logic [15:0] v);
    dist_valid = 1'b1;
    dist_mm    = v;
    @(negedge fastclk);
    dist_valid = 1'b0;
    dist_mm    = 16'hDEAD;
  endtask

  task automatic send(input logic [15:0] v, output int t0);
    @(negedge fastclk);
    pulse(v);
    t0 = cyc;
    check("busy_rise", 32'(busy), 1);
  endtask

  function automatic logic [6:0][7:0] line_of(input string s);
    logic [6:0][7:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = s[i];
    r[s.len()]     = 8'h0D;
    r[s.len() + 1] = 8'h0A;
    return r;
  endfunction

  // Cycles uart_tx stays low from the start bit: start + trailing zero data bits.
  function automatic int low_bits(input logic [7:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic rx_byte(output logic [7:0] b, output int fall, output int low, output bit ok);
    int j;
    ok = 1'b0; b = 8'h00; fall = 0; low = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge fastclk);
      if (uart_tx === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    fall = cyc;
    for (int p = 1; p <= CPB/2 + 9*CPB; p++) begin
      @(negedge fastclk);
      if (low < 0 && uart_tx === 1'b1) low = p;
      if (p >= CPB/2 && (p - CPB/2) % CPB == 0) begin
        j = (p - CPB/2) / CPB;
        if (j == 0)      check("start_bit", 32'(uart_tx), 0);
        else if (j <= 8) b[j-1] = uart_tx;
        else             check("stop_bit", 32'(uart_tx), 1);
      end
    end
  endtask

  task automatic rx_line(input string tag, input logic [6:0][7:0] exp, input int n,
                         input int first_fall, input bit busy_after, output int last_fall);
    logic [7:0] b;
    int f, l, prev;
    bit ok;
    prev = 0;
    last_fall = 0;
    for (int i = 0; i < n; i++) begin
      rx_byte(b, f, l, ok);
      if (!ok) begin
        check({tag, " rx_timeout"}, 0, 1);
        return;
      end
      check({tag, " byte"}, 32'(b), 32'(exp[i]));
      check({tag, " char_start"}, f, (i == 0) ? first_fall : prev + CHAR);
      check({tag, " low_run"}, l, CPB * low_bits(exp[i]));
      prev = f;
    end
    last_fall = prev;
    wait_cyc(prev + CHAR);
    check({tag, " busy_dispatch"}, 32'(busy), 1);
    @(negedge fastclk);
    check({tag, " busy_after"}, 32'(busy), 32'(busy_after));
  endtask

  int    t0, lf;
  int    vals [6] = '{1234, 0, 8189, 1005, 8190, 65535};
  string txts [6] = '{"1234", "0", "8189", "1005", "OOR", "OOR"};

  initial begin
    repeat (3) @(negedge fastclk);
    check("rst uart_tx", 32'(uart_tx), 1);
    check("rst busy", 32'(busy), 0);
    check("rst drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge fastclk);

    // Single samples, normal latency, text and out-of-range boundaries.
    for (int i = 0; i < 6; i++) begin
      send(16'(vals[i]), t0);
      rx_line(txts[i], line_of(txts[i]), txts[i].len() + 2, t0 + 17, 1'b0, lf);
    end
    check("drop after singles", 32'(drop_cnt), 0);

    // A in flight, B then C arrive: B is overwritten by C.
    send(16'd100, t0);
    fork
      rx_line("100", line_of("100"), 5, t0 + 17, 1'b1, lf);
      begin
        wait_cyc(t0 + 100); pulse(16'd200);
        wait_cyc(t0 + 300); pulse(16'd300);
      end
    join
    check("drop after B/C", 32'(drop_cnt), 1);
    rx_line("300", line_of("300"), 5, lf + CHAR + 18, 1'b0, lf);

    // Sample strobed in the DISPATCH cycle itself, pending empty.
    send(16'd7, t0);
    fork
      rx_line("7", line_of("7"), 3, t0 + 17, 1'b1, lf);
      begin
        wait_cyc(t0 + 17 + 2*CHAR + CHAR);
        pulse(16'd500);
      end
    join
    rx_line("500", line_of("500"), 5, lf + CHAR + 18, 1'b0, lf);
    check("drop after dispatch hit", 32'(drop_cnt), 1);

    // 300 back-to-back strobes during a line: saturation, last value wins.
    send(16'd9, t0);
    fork
      rx_line("9", line_of("9"), 3, t0 + 17, 1'b1, lf);
      begin
        for (int i = 0; i < 300; i++) begin
          dist_valid = 1'b1;
          dist_mm    = (i == 299) ? 16'd77 : 16'(1000 + i);
          @(negedge fastclk);
        end
        dist_valid = 1'b0;
      end
    join
    check("drop saturated", 32'(drop_cnt), 255);
    rx_line("77", line_of("77"), 4, lf + CHAR + 18, 1'b0, lf);

    // Reset during data bit 0 of the second character ('2' = 0x32, bit0 = 0).
    send(16'd1234, t0);
    wait_cyc(t0 + 17 + CHAR + CPB + CPB/2);
    check("mid-frame tx low", 32'(uart_tx), 0);
    rst = 1'b1;
    @(negedge fastclk);
    check("rst mid uart_tx", 32'(uart_tx), 1);
    check("rst mid busy", 32'(busy), 0);
    check("rst mid drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge fastclk);
    check("abandoned line idle", 32'(uart_tx), 1);
    send(16'd42, t0);
    rx_line("42", line_of("42"), 4, t0 + 17, 1'b0, lf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/distance_uart_reporter.md
Name: distance_uart_reporter

Overview:
- Downstream consumer of the VL53L0X I2C ranging sequencer.
- Accepts each 16-bit distance sample (mm) when the sequencer publishes it.
- Converts the sample to decimal ASCII with an iterative double-dabble and streams it as a text line over a UART TX pin (8N1) for host-side logging.
- Holds one pending sample while a line is in flight; reports overruns.

Parameters:
- CLKS_PER_BIT, 217: fastclk cycles per UART bit (25 MHz / 115200).
- OOR_MM, 8190: samples >= this value are reported as out-of-range text.

Ports:
- fastclk  input  1  system clock, 25 MHz
- rst  input  1  synchronous, active-high reset
- dist_valid  input  1  one-cycle pulse; dist_mm valid this cycle
- dist_mm  input  16  distance sample in mm, unsigned
- uart_tx  output  1  UART serial out, idle high
- busy  output  1  high from sample capture until the last stop bit of its line completes
- drop_cnt  output  8  saturating count of overwritten pending samples

Behaviour:
- Reset is synchronous and active-high on rst, clock fastclk.
  - Resets: uart_tx=1, busy=0, drop_cnt=0, pending empty, FSM=IDLE, all counters 0.
  - rst asserted mid-frame: uart_tx=1 on the next edge and any partial line is abandoned.
- Line format:
  - Decimal digits with leading zeros suppressed; value 0 prints a single "0".
  - The line ends with 0x0D 0x0A.
  - If dist_mm >= OOR_MM, the line is "OOR" 0x0D 0x0A instead of digits.
- UART framing:
  - Start bit 0, then 8 data bits LSB first, then one stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Characters within a line are back-to-back with no idle gap.
- States: IDLE, CONVERT, LOAD, START, DATA, STOP, DISPATCH.
  - IDLE: if dist_valid, latch dist_mm into the work register, set busy=1, go to CONVERT.
  - CONVERT: 16 cycles of shift-add-3 double-dabble on a 20-bit BCD (5 digits) plus 16-bit shift register. Then go to LOAD.
  - LOAD: in one cycle, build the character list (up to 7 bytes), index=0, go to START.
  - START / DATA / STOP: serialize the current byte.
    - After STOP, if more bytes remain: index+1, go to START.
    - Otherwise go to DISPATCH.
  - DISPATCH: one cycle.
    - If pending is full: move it to the work register, clear pending, go to CONVERT with busy held at 1.
    - Otherwise busy=0, go to IDLE.
- Latency:
  - dist_valid in IDLE at cycle N: CONVERT occupies N+1..N+16, LOAD is N+17, uart_tx falls at N+18.
  - Line duration is 10*CLKS_PER_BIT*bytes cycles.
- Pending buffer, one-deep:
  - dist_valid in any state other than IDLE writes dist_mm into pending.
  - If pending was already full, the old value is overwritten and drop_cnt increments, saturating at 255.
  - dist_valid coincident with DISPATCH writes pending first. DISPATCH therefore sees the new value (no drop if pending was empty).
- OOR comparison is made on the latched value. Conversion still runs so latency is identical.
- Width rules:
  - 65535 produces 5 digits, the maximum.
  - No sign handling; inputs are unsigned.
- dist_mm is ignored when dist_valid=0.

Test Plan:
- Reset, then dist_valid with dist_mm=1234 → busy rises next cycle, uart_tx falls at N+18, decoded bytes 0x31 0x32 0x33 0x34 0x0D 0x0A, busy=0 after DISPATCH.
- dist_mm=0 → bytes 0x30 0x0D 0x0A. dist_mm=8189 → 0x38 0x31 0x38 0x39 0x0D 0x0A. dist_mm=1005 → "1005" (interior zeros kept).
- dist_mm=8190 and dist_mm=65535 → each gives 0x4F 0x4F 0x52 0x0D 0x0A. Check bit period is exactly 217 cycles and a bit-width checker passes.
- Samples A=100, then B=200 and C=300 during A's line → output "100\r\n" then "300\r\n", drop_cnt=1, busy stays high between lines, with exactly one DISPATCH cycle followed by 16 CONVERT cycles.
- dist_valid=500 during the DISPATCH cycle of a prior line, pending empty → "500\r\n" follows immediately, drop_cnt unchanged. 300 overflow pulses → drop_cnt saturates at 255.
- rst asserted mid-data-bit of the second character → uart_tx=1 and busy=0 on the next edge, drop_cnt=0. A fresh sample of 42 then yields "42\r\n" with normal latency.
